surf_align_ctrl: RTL

//  Automatic per-channel input alignment for the SURF COUT/DOUT receive path, sysclk domain.
//  For each of NCH ISERDES channels: sweeps the IDELAY tap, finds the widest stable eye and centres in it.

---
 rtl/surf_align_pkg.sv | 33 +++
 rtl/surf_align_if.sv | 28 ++
 rtl/surf_eye_tracker.sv | 56 +++++
 rtl/surf_align_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/surf_align_pkg.sv
// Shared types for the SURF COUT/DOUT receive alignment controller.
// Holds the FSM state encoding, the alignment phase tag and the per-channel status record.
package surf_align_pkg;

  localparam int DLY_BITS_DEF = 5;
  localparam int NTAPS        = 2 ** DLY_BITS_DEF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_NEXT_CH,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT_TAP,
    ST_CENTER,
    ST_SLIP_CHECK,
    ST_SLIP_PULSE,
    ST_DONE
  } align_state_t;

  // What a LOAD/SETTLE pair is in service of: tap sweep, word alignment, or parking at tap 0.
  typedef enum logic [1:0] {
    PH_SWEEP,
    PH_ALIGN,
    PH_ZERO
  } align_phase_t;

  typedef struct packed {
    logic                  locked;
    logic [DLY_BITS_DEF:0] eye_width;
  } chan_status_t;

endpackage

// File: rtl/surf_align_if.sv
// Control and PHY-facing signals of the alignment controller.
// master = controller side, slave = host/PHY side.
interface surf_align_if #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 8,
  parameter int DLY_BITS = 5
);
  logic                      start_i;
  logic [NCH-1:0]            chan_mask_i;
  logic [NCH*WIDTH-1:0]      data_i;
  logic [DLY_BITS-1:0]       idelay_value_o;
  logic [NCH-1:0]            idelay_load_o;
  logic [NCH-1:0]            bitslip_o;
  logic                      busy_o;
  logic                      done_o;
  logic [NCH-1:0]            locked_o;
  logic [NCH*(DLY_BITS+1)-1:0] eye_width_o;

  modport master (
    input  start_i, chan_mask_i, data_i,
    output idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o, locked_o, eye_width_o
  );

  modport slave (
    output start_i, chan_mask_i, data_i,
    input  idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o, locked_o, eye_width_o
  );
endinterface

// File: rtl/surf_eye_tracker.sv
// Tracks runs of consecutive passing taps during a sweep and keeps the longest one.
// Strict '>' on update means the lowest-start run wins a tie; no wrap past the top tap.
module surf_eye_tracker #(
  parameter int DLY_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                pass,
  input  logic                fail,
  input  logic                last_tap,
  input  logic [DLY_BITS-1:0] tap,
  output logic [DLY_BITS-1:0] best_start,
  output logic [DLY_BITS:0]   best_len
);

  logic [DLY_BITS-1:0] cur_start;
  logic [DLY_BITS:0]   cur_len;
  logic [DLY_BITS-1:0] close_start;
  logic [DLY_BITS:0]   close_len;
  logic                close_en;

  always_comb begin
    close_start = cur_start;
    close_len   = cur_len;
    close_en    = 1'b0;
    if (pass) begin
      close_start = (cur_len == '0) ? tap : cur_start;
      close_len   = cur_len + 1'b1;
      close_en    = last_tap;
    end else if (fail) begin
      close_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      if (pass) begin
        cur_start <= close_start;
        cur_len   <= close_len;
      end else if (fail) begin
        cur_len <= '0;
      end
      if (close_en && (close_len > best_len)) begin
        best_start <= close_start;
        best_len   <= close_len;
      end
    end
  end

endmodule

// File: rtl/surf_align_ctrl.sv
// Per-channel IDELAY eye search and bitslip word alignment for the SURF receive path.
// Channels are handled one at a time, lowest index first.
module surf_align_ctrl
  import surf_align_pkg::*;
#(
  parameter int         NCH           = 2,
  parameter int         WIDTH         = 8,
  parameter logic [7:0] TRAIN_PATTERN = 8'hA9,
  parameter int         DLY_BITS      = DLY_BITS_DEF,
  parameter int         SETTLE        = 16,
  parameter int         NSAMP         = 64,
  parameter int         MIN_EYE       = 4
) (
  input logic          sysclk_i,
  input logic          rst_n_i,
  surf_align_if.master bus
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MAXC   = (SETTLE > NSAMP) ? SETTLE : NSAMP;
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam int SLIP_W = $clog2(WIDTH + 1);
  localparam logic [DLY_BITS-1:0] TOP_TAP = '1;
  localparam logic [WIDTH-1:0]    PATTERN = TRAIN_PATTERN[WIDTH-1:0];

  align_state_t           state_q, state_d;
  align_phase_t           phase_q;
  logic [CH_W-1:0]        ch_q, next_ch;
  logic [NCH-1:0]         pending_q;
  logic                   have_ch;
  logic [DLY_BITS-1:0]    tap_q, dly_q, centre;
  logic [CNT_W-1:0]       cnt_q;
  logic [SLIP_W-1:0]      slips_q;
  logic [1:0]             match_q;
  logic [WIDTH-1:0]       word, ref_q;
  logic                   ok_q, eye_short;
  logic [NCH-1:0]         locked_q;
  logic [NCH*(DLY_BITS+1)-1:0] eye_q;
  logic [DLY_BITS-1:0]    best_start;
  logic [DLY_BITS:0]      best_len;

  assign word      = bus.data_i[ch_q*WIDTH +: WIDTH];
  assign centre    = best_start + DLY_BITS'(best_len >> 1);
  assign eye_short = best_len < (DLY_BITS+1)'(MIN_EYE);

  // Pick the lowest still-pending channel so masked channels cost no cycles.
  always_comb begin
    next_ch = '0;
    have_ch = |pending_q;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_q[i]) next_ch = CH_W'(i);
    end
  end

  surf_eye_tracker #(.DLY_BITS(DLY_BITS)) u_tracker (
    .clk        (sysclk_i),
    .rst_n      (rst_n_i),
    .clear      (state_q == ST_NEXT_CH),
    .pass       ((state_q == ST_NEXT_TAP) && ok_q),
    .fail       ((state_q == ST_NEXT_TAP) && !ok_q),
    .last_tap   (tap_q == TOP_TAP),
    .tap        (tap_q),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (bus.start_i) state_d = ST_NEXT_CH;
      ST_NEXT_CH:    state_d = have_ch ? ST_LOAD : ST_DONE;
      ST_LOAD:       state_d = (phase_q == PH_ZERO) ? ST_NEXT_CH : ST_SETTLE;
      ST_SETTLE:     if (cnt_q == CNT_W'(SETTLE - 1))
                       state_d = (phase_q == PH_SWEEP) ? ST_SAMPLE : ST_SLIP_CHECK;
      ST_SAMPLE:     if (cnt_q == CNT_W'(NSAMP - 1)) state_d = ST_NEXT_TAP;
      ST_NEXT_TAP:   state_d = (tap_q == TOP_TAP) ? ST_CENTER : ST_LOAD;
      ST_CENTER:     state_d = ST_LOAD;
      ST_SLIP_CHECK: begin
        if (word == PATTERN) begin
          if (match_q == 2'd3) state_d = ST_NEXT_CH;
        end else if (slips_q == SLIP_W'(WIDTH)) begin
          state_d = ST_NEXT_CH;
        end else begin
          state_d = ST_SLIP_PULSE;
        end
      end
      ST_SLIP_PULSE: state_d = ST_SETTLE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // dly_q is updated one cycle ahead of LOAD so the value is valid alongside the strobe.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      phase_q   <= PH_SWEEP;
      ch_q      <= '0;
      pending_q <= '0;
      tap_q     <= '0;
      dly_q     <= '0;
      cnt_q     <= '0;
      slips_q   <= '0;
      match_q   <= '0;
      ref_q     <= '0;
      ok_q      <= 1'b0;
      locked_q  <= '0;
      eye_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_i) begin
          pending_q <= bus.chan_mask_i;
          locked_q  <= '0;
          eye_q     <= '0;
        end
        ST_NEXT_CH: if (have_ch) begin
          ch_q               <= next_ch;
          pending_q[next_ch] <= 1'b0;
          phase_q            <= PH_SWEEP;
          tap_q              <= '0;
          dly_q              <= '0;
        end
        ST_LOAD:   cnt_q <= '0;
        ST_SETTLE: cnt_q <= (cnt_q == CNT_W'(SETTLE - 1)) ? '0 : cnt_q + 1'b1;
        ST_SAMPLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) begin
            ref_q <= word;
            ok_q  <= 1'b1;
          end else if (word != ref_q) begin
            ok_q <= 1'b0;
          end
        end
        ST_NEXT_TAP: if (tap_q != TOP_TAP) begin
          tap_q <= tap_q + 1'b1;
          dly_q <= tap_q + 1'b1;
        end
        ST_CENTER: begin
          eye_q[ch_q*(DLY_BITS+1) +: (DLY_BITS+1)] <= best_len;
          slips_q <= '0;
          match_q <= '0;
          if (eye_short) begin
            phase_q <= PH_ZERO;
            dly_q   <= '0;
          end else begin
            phase_q <= PH_ALIGN;
            dly_q   <= centre;
          end
        end
        ST_SLIP_CHECK: begin
          if (word == PATTERN) begin
            match_q <= match_q + 1'b1;
            if (match_q == 2'd3) locked_q[ch_q] <= 1'b1;
          end else begin
            match_q <= '0;
          end
        end
        ST_SLIP_PULSE: slips_q <= slips_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.idelay_load_o = '0;
    bus.bitslip_o     = '0;
    if (state_q == ST_LOAD)       bus.idelay_load_o[ch_q] = 1'b1;
    if (state_q == ST_SLIP_PULSE) bus.bitslip_o[ch_q]     = 1'b1;
    bus.busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    bus.done_o         = (state_q == ST_DONE);
    bus.idelay_value_o = dly_q;
    bus.locked_o       = locked_q;
    bus.eye_width_o    = eye_q;
  end

endmodule
